cordic_div_p: RTL

Parameterised successor to the team's fixed 16-bit CORDIC linear-mode divider. Computes a signed fixed-point quotient by shift-add iteration, one quotient digit per clock. Over the earlier block it adds:
- signed divisor support
- a final correction step giving exact truncation toward zero
- saturation and divide-by-zero flags
- a valid/ready handshake on both sides

Used in the DeSTIN datapath wherever a normalisation or ratio is needed.

---
 rtl/cordic_div_p.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cordic_div_p.sv
// Signed fixed-point shift-add divider, one quotient digit per clock, valid/ready on both sides.
// Define CORDIC_DIV_REM_EN to add the signed remainder output rem.
module cordic_div_p #(
  parameter int DW = 16,
  parameter int FB = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] dividend,
  input  logic signed [DW-1:0] divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] quotient,
  output logic                 ovf,
  output logic                 dz
`ifdef CORDIC_DIV_REM_EN
  ,
  output logic signed [DW-1:0] rem
`endif
);

  localparam int RW = 2*DW + FB + 2;
  localparam int ZW = DW + 2;
  localparam int KW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic signed [ZW-1:0] QMAX = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [ZW-1:0] QMIN = {3'b111, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, CORR, DONE} state_t;

  state_t                state;
  logic signed [RW-1:0]  y;
  logic signed [RW-1:0]  x;
  logic signed [ZW-1:0]  z;
  logic [KW-1:0]         k;
  logic                  dsign;

  logic signed [RW-1:0]  xs;
  logic signed [RW-1:0]  y_step;
  logic signed [RW-1:0]  y_corr;
  logic signed [ZW-1:0]  zbit;
  logic signed [ZW-1:0]  z_step;
  logic signed [ZW-1:0]  z_corr;
  logic signed [DW-1:0]  q_sat;
  logic                  clip;

  always_comb begin
    xs     = x <<< k;
    zbit   = ZW'(1) << k;
    y_step = y;
    z_step = z;
    if (y != '0) begin
      if (y[RW-1] == x[RW-1]) begin
        z_step = z + zbit;
        y_step = y - xs;
      end else begin
        z_step = z - zbit;
        y_step = y + xs;
      end
    end

    // Non-restoring digits leave the residual one divisor past zero at most;
    // a single step back restores truncation toward zero.
    y_corr = y;
    z_corr = z;
    if (y != '0 && y[RW-1] != dsign) begin
      if (y[RW-1] != x[RW-1]) begin
        z_corr = z - ZW'(1);
        y_corr = y + x;
      end else begin
        z_corr = z + ZW'(1);
        y_corr = y - x;
      end
    end

    clip  = 1'b0;
    q_sat = z_corr[DW-1:0];
    if (z_corr > QMAX) begin
      clip  = 1'b1;
      q_sat = {1'b0, {(DW-1){1'b1}}};
    end else if (z_corr < QMIN) begin
      clip  = 1'b1;
      q_sat = {1'b1, {(DW-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
      y         <= '0;
      x         <= '0;
      z         <= '0;
      k         <= '0;
      dsign     <= 1'b0;
`ifdef CORDIC_DIV_REM_EN
      rem       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            dsign    <= dividend[DW-1];
            if (divisor == '0) begin
              state    <= DONE;
              dz       <= 1'b1;
              ovf      <= 1'b0;
              quotient <= dividend[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`ifdef CORDIC_DIV_REM_EN
              rem      <= '0;
`endif
            end else begin
              state <= ITER;
              dz    <= 1'b0;
              y     <= {{(RW-DW){dividend[DW-1]}}, dividend} <<< FB;
              x     <= {{(RW-DW){divisor[DW-1]}}, divisor};
              z     <= '0;
              k     <= KW'(DW-1);
            end
          end
        end
        ITER: begin
          y <= y_step;
          z <= z_step;
          if (k == '0) state <= CORR;
          else         k     <= k - KW'(1);
        end
        CORR: begin
          y        <= y_corr;
          z        <= z_corr;
          quotient <= q_sat;
          ovf      <= clip;
`ifdef CORDIC_DIV_REM_EN
          rem      <= clip ? '0 : y_corr[DW-1:0];
`endif
          state    <= DONE;
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
